// File: rtl/dht11_pkg.sv
// dht11_pkg: shared state encoding, widths and divider helpers for the
// DHT11 sampler. The CONV state exists only when DHT11_BCD_EN is defined.
package dht11_pkg;

   // Width of a 3-digit BCD value (hundreds, tens, units)
   localparam int BCD_W = 12;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_KICK      = 3'd1,
      ST_WAIT_DONE = 3'd2,
      ST_FAIL      = 3'd3,
      ST_GAP       = 3'd4
`ifdef DHT11_BCD_EN
      ,
      ST_CONV      = 3'd5
`endif
   } dht_state_t;

   // Clock cycles per 1 ms tick
   function automatic int ms_div(input int clk_hz);
      return clk_hz / 1000;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // One spare bit above the largest duration so the ms counter never wraps
   function automatic int ms_cnt_w(input int a, input int b, input int c);
      return $clog2(max3(a, b, c)) + 1;
   endfunction

endpackage

// File: rtl/bcd8_dabble.sv
// bcd8_dabble: sequential shift-add-3 (double dabble) converter, 8-bit
// binary to 3-digit BCD. A one-cycle start loads the byte; done pulses
// eight cycles later with the result held on bcd until the next start.
module bcd8_dabble
   import dht11_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       bin,
   output logic [BCD_W-1:0] bcd,
   output logic             done
);

   logic [7:0]       r_bin;
   logic [BCD_W-1:0] r_bcd;
   logic [3:0]       r_cnt;
   logic             r_done;
   logic [BCD_W-1:0] w_adj;

   // Add 3 to every digit that is 5 or more, so the following shift
   // carries correctly into the next decade
   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < 3; i++) begin
         if (r[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   assign w_adj = add3(r_bcd);

   // Shift engine: the start cycle performs the first shift directly on
   // the input byte (all digits are still zero, so no adjust is needed),
   // seven further shifts follow, and done rises with the last one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bin  <= '0;
         r_bcd  <= '0;
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (start) begin
            r_bcd <= {{(BCD_W-1){1'b0}}, bin[7]};
            r_bin <= {bin[6:0], 1'b0};
            r_cnt <= 4'd7;
         end else if (r_cnt != 4'd0) begin
            r_bcd <= {w_adj[BCD_W-2:0], r_bin[7]};
            r_bin <= {r_bin[6:0], 1'b0};
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               r_done <= 1'b1;
            end
         end
      end
   end

   assign bcd  = r_bcd;
   assign done = r_done;

endmodule

// File: rtl/dht11_sampler.sv
// dht11_sampler: periodic acquisition manager in front of dht11_controller.
// Kicks a read every PERIOD_MS (or on start_req), waits for dht_done with a
// timeout, retries up to MAX_RETRY times after RETRY_MS gaps, and holds the
// last good humidity/temperature pair. Defining DHT11_BCD_EN adds a CONV
// state and BCD outputs rh_bcd/t_bcd, updated together with update.
module dht11_sampler
   import dht11_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int PERIOD_MS  = 2000,
   parameter int TIMEOUT_MS = 50,
   parameter int RETRY_MS   = 1000,
   parameter int MAX_RETRY  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start_req,
   input  logic             dht_done,
   input  logic             dht_valid,
   input  logic [7:0]       rh_in,
   input  logic [7:0]       t_in,
   output logic             dht_start,
   output logic [7:0]       rh_data,
   output logic [7:0]       t_data,
   output logic             data_valid,
   output logic             err,
   output logic             busy,
   output logic             update
`ifdef DHT11_BCD_EN
   ,
   output logic [BCD_W-1:0] rh_bcd,
   output logic [BCD_W-1:0] t_bcd
`endif
);

   localparam int DIV   = ms_div(CLK_HZ);
   localparam int DIV_W = $clog2(DIV + 1);
   localparam int MS_W  = ms_cnt_w(PERIOD_MS, TIMEOUT_MS, RETRY_MS);
   localparam int RTY_W = $clog2(MAX_RETRY + 1) + 1;

   // Terminal values: a limit is "reached" on the tick that brings the
   // count from limit-1 to limit, so compare against limit-1 with the tick
   localparam logic [DIV_W-1:0] DIV_M1     = DIV_W'(DIV - 1);
   localparam logic [MS_W-1:0]  PERIOD_M1  = MS_W'(PERIOD_MS - 1);
   localparam logic [MS_W-1:0]  TIMEOUT_M1 = MS_W'(TIMEOUT_MS - 1);
   localparam logic [MS_W-1:0]  RETRY_M1   = MS_W'(RETRY_MS - 1);
   localparam logic [RTY_W-1:0] MAX_RTY    = RTY_W'(MAX_RETRY);

   dht_state_t       r_state;
   logic [DIV_W-1:0] r_div;
   logic [MS_W-1:0]  r_ms;
   logic [RTY_W-1:0] r_retry;
   logic             r_dht_start;
   logic [7:0]       r_rh_data;
   logic [7:0]       r_t_data;
   logic             r_data_valid;
   logic             r_err;
   logic             r_update;
   logic             w_tick;

`ifdef DHT11_BCD_EN
   logic             r_conv_start;
   logic [BCD_W-1:0] r_rh_bcd;
   logic [BCD_W-1:0] r_t_bcd;
   logic [BCD_W-1:0] w_rh_bcd;
   logic [BCD_W-1:0] w_t_bcd;
   logic             w_rh_done;
   logic             w_t_done;
   logic             w_conv_done;
`endif

   assign w_tick = (r_div == DIV_M1);

   // Free-running 1 ms tick divider, independent of state and enable
   // NOTE: every clocked register here uses <= so all of them see the
   // pre-edge values of each other; = would make results order-dependent.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div <= '0;
      end else if (w_tick) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   // Acquisition FSM with registered outputs; the ms counter is cleared on
   // every state change and on enable drop, so each state times from zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_ms         <= '0;
         r_retry      <= '0;
         r_dht_start  <= 1'b0;
         r_rh_data    <= '0;
         r_t_data     <= '0;
         r_data_valid <= 1'b0;
         r_err        <= 1'b0;
         r_update     <= 1'b0;
`ifdef DHT11_BCD_EN
         r_conv_start <= 1'b0;
         r_rh_bcd     <= '0;
         r_t_bcd      <= '0;
`endif
      end else begin
         r_dht_start <= 1'b0;
         r_update    <= 1'b0;
`ifdef DHT11_BCD_EN
         r_conv_start <= 1'b0;
`endif
         if (!en) begin
            // Abort anything in flight; a late dht_done lands in IDLE
            r_state <= ST_IDLE;
            r_ms    <= '0;
            r_retry <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (start_req || (w_tick && r_ms == PERIOD_M1)) begin
                     r_state     <= ST_KICK;
                     r_dht_start <= 1'b1;
                     r_ms        <= '0;
                  end else if (w_tick) begin
                     r_ms <= r_ms + 1'b1;
                  end
               end
               ST_KICK: begin
                  r_state <= ST_WAIT_DONE;
                  r_ms    <= '0;
               end
               ST_WAIT_DONE: begin
                  if (dht_done && dht_valid) begin
                     r_rh_data    <= rh_in;
                     r_t_data     <= t_in;
                     r_data_valid <= 1'b1;
                     r_err        <= 1'b0;
                     r_retry      <= '0;
                     r_ms         <= '0;
`ifdef DHT11_BCD_EN
                     r_state      <= ST_CONV;
                     r_conv_start <= 1'b1;
`else
                     r_state      <= ST_IDLE;
                     r_update     <= 1'b1;
`endif
                  end else if (dht_done || (w_tick && r_ms == TIMEOUT_M1)) begin
                     r_state <= ST_FAIL;
                     r_ms    <= '0;
                  end else if (w_tick) begin
                     r_ms <= r_ms + 1'b1;
                  end
               end
               ST_FAIL: begin
                  r_ms <= '0;
                  if (r_retry < MAX_RTY) begin
                     r_retry <= r_retry + 1'b1;
                     r_state <= ST_GAP;
                  end else begin
                     // Retries exhausted: flag it, keep the held data
                     r_err   <= 1'b1;
                     r_retry <= '0;
                     r_state <= ST_IDLE;
                  end
               end
               ST_GAP: begin
                  if (w_tick && r_ms == RETRY_M1) begin
                     r_state     <= ST_KICK;
                     r_dht_start <= 1'b1;
                     r_ms        <= '0;
                  end else if (w_tick) begin
                     r_ms <= r_ms + 1'b1;
                  end
               end
`ifdef DHT11_BCD_EN
               ST_CONV: begin
                  // BCD and update move together so they never disagree
                  if (w_conv_done) begin
                     r_rh_bcd <= w_rh_bcd;
                     r_t_bcd  <= w_t_bcd;
                     r_update <= 1'b1;
                     r_state  <= ST_IDLE;
                     r_ms     <= '0;
                  end
               end
`endif
               default: begin
                  r_state <= ST_IDLE;
                  r_ms    <= '0;
               end
            endcase
         end
      end
   end

`ifdef DHT11_BCD_EN
   // Both converters start together from the freshly latched bytes
   bcd8_dabble u_rh_bcd (
      .clk   (clk),
      .rst   (rst),
      .start (r_conv_start),
      .bin   (r_rh_data),
      .bcd   (w_rh_bcd),
      .done  (w_rh_done)
   );

   bcd8_dabble u_t_bcd (
      .clk   (clk),
      .rst   (rst),
      .start (r_conv_start),
      .bin   (r_t_data),
      .bcd   (w_t_bcd),
      .done  (w_t_done)
   );

   assign w_conv_done = w_rh_done & w_t_done;
   assign rh_bcd      = r_rh_bcd;
   assign t_bcd       = r_t_bcd;
`endif

   assign dht_start  = r_dht_start;
   assign rh_data    = r_rh_data;
   assign t_data     = r_t_data;
   assign data_valid = r_data_valid;
   assign err        = r_err;
   assign busy       = (r_state != ST_IDLE);
   assign update     = r_update;

endmodule
